// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word
// geometry and wait-state counter width.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with per-lane write enables and a registered read
// port. The read register only updates on a read strobe, so it holds the
// last loaded word while a response is pending. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              re_i,
  input  logic [LANES-1:0]  we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Lane-masked write and strobed registered read on the same port.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store path. One request per handshake,
// LATENCY wait states, then a response held until the initiator takes it.
// The array is read or written on the edge that enters RESP; a request that
// arrives while a response is being retired is accepted on the same edge.
// Optional build macro: DMEM_BYTE_ENABLE_EN (honour req_be per byte lane;
// when undefined every store writes the full word).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rd_sel_q, rd_sel_d;

  logic              hold_we_q;
  logic [WORD_W-1:0] hold_addr_q;
  logic [WORD_W-1:0] hold_wdata_q;
  logic [LANES-1:0]  hold_be_q;

  logic              accept;
  logic              from_hold;
  logic              from_req;
  logic              commit;
  logic              c_we;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic [LANES-1:0]  c_be;
  logic              c_err;
  logic              arr_re;
  logic [LANES-1:0]  arr_we;
  logic [WORD_W-1:0] arr_rdata;

  // Misaligned, or any address bit above the word-index field set.
  function automatic logic addr_err(input logic [WORD_W-1:0] a);
    addr_err = (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  // Lanes actually written by a store.
  function automatic logic [LANES-1:0] lane_mask(input logic [LANES-1:0] be);
`ifdef DMEM_BYTE_ENABLE_EN
    lane_mask = be;
`else
    lane_mask = {LANES{1'b1}};
`endif
  endfunction

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // The commit either comes straight from the request port (zero wait
  // states) or from the holding registers when the wait count expires.
  assign from_hold = (state_q == ST_WAIT) && (cnt_q == '0);
  assign from_req  = accept && (LATENCY == 0);
  assign commit    = from_hold || from_req;

  assign c_we    = from_hold ? hold_we_q    : req_we;
  assign c_addr  = from_hold ? hold_addr_q  : req_addr;
  assign c_wdata = from_hold ? hold_wdata_q : req_wdata;
  assign c_be    = from_hold ? hold_be_q    : req_be;
  assign c_err   = addr_err(c_addr);

  assign arr_re = commit && !c_we && !c_err;
  assign arr_we = (commit && c_we && !c_err) ? lane_mask(c_be) : '0;

`ifndef DMEM_BYTE_ENABLE_EN
  logic unused_be;
  assign unused_be = ^c_be;
`endif

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .re_i    (arr_re),
    .we_i    (arr_we),
    .idx_i   (c_addr[IDX_W+1:2]),
    .wdata_i (c_wdata),
    .rdata_o (arr_rdata)
  );

  // Next-state logic: accept, wait countdown, retire; commit wins last.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rd_sel_d = rd_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d    = 1'b0;
          rd_sel_d = 1'b0;
          if (req_valid) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      state_d  = ST_RESP;
      err_d    = c_err;
      rd_sel_d = !c_we && !c_err;
    end
  end

  // Control state with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Request holding registers, loaded on every accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_we_q    <= req_we;
      hold_addr_q  <= req_addr;
      hold_wdata_q <= req_wdata;
      hold_be_q    <= req_be;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances with LATENCY 2, 0 and 3
// share clock and reset; index 0 = LATENCY 2, 1 = LATENCY 0, 2 = LATENCY 3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid [3];
  logic        req_we    [3];
  logic        rsp_ready [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_err   [3];
  logic        busy      [3];
  logic [31:0] rsp_rdata [3];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance i with rsp_ready held high. Returns the
  // response data/error, the number of edges after the accept edge before
  // rsp_valid is seen, and whether every waiting cycle showed req_ready=0
  // and busy=1.
  task automatic txn(input int i, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rd, output logic er,
                     output int lat, output logic stall_ok);
    int n;
    @(negedge clk);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wdata; req_be[i] = be; rsp_ready[i] = 1'b1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", req_ready[i], 32'd1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    lat = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    while (rsp_valid[i] !== 1'b1 && lat < 20) begin
      if (req_ready[i] !== 1'b0 || busy[i] !== 1'b1) stall_ok = 1'b0;
      lat++;
      @(negedge clk);
    end
    if (lat >= 20) check("rsp_timeout", rsp_valid[i], 32'd1);
    rd = rsp_rdata[i];
    er = rsp_err[i];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        ok;
    logic [31:0] exp_lane;
    logic [31:0] exp_be0;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; rsp_ready[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values on every instance.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_req_ready%0d", i), req_ready[i], 32'd1);
      check($sformatf("rst_rsp_valid%0d", i), rsp_valid[i], 32'd0);
      check($sformatf("rst_rsp_rdata%0d", i), rsp_rdata[i], 32'd0);
      check($sformatf("rst_rsp_err%0d", i), rsp_err[i], 32'd0);
      check($sformatf("rst_busy%0d", i), busy[i], 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Reset-load timing with two wait states.
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, ok);
    check("rl_latency", lat, 32'd2);
    check("rl_wait_ready_busy", ok, 32'd1);
    check("rl_err", er, 32'd0);
    @(negedge clk);
    check("rl_busy_after", busy[0], 32'd0);
    check("rl_valid_after", rsp_valid[0], 32'd0);

    // Store then load.
    txn(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, er, lat, ok);
    check("st_err", er, 32'd0);
    check("st_rdata_zero", rd, 32'd0);
    check("st_latency", lat, 32'd2);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, ok);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", er, 32'd0);

    // Byte lanes.
`ifdef DMEM_BYTE_ENABLE_EN
    exp_lane = 32'h11BB33DD;
    exp_be0  = 32'hCAFEBABE;
`else
    exp_lane = 32'hAABBCCDD;
    exp_be0  = 32'h00000000;
`endif
    txn(0, 1'b1, 32'h24, 32'h11223344, 4'hF, rd, er, lat, ok);
    txn(0, 1'b1, 32'h24, 32'hAABBCCDD, 4'b0101, rd, er, lat, ok);
    check("lane_st_err", er, 32'd0);
    txn(0, 1'b0, 32'h24, 32'h0, 4'hF, rd, er, lat, ok);
    check("lane_rdata", rd, exp_lane);

    // Store with no lanes enabled.
    txn(0, 1'b1, 32'h28, 32'hCAFEBABE, 4'hF, rd, er, lat, ok);
    txn(0, 1'b1, 32'h28, 32'h00000000, 4'h0, rd, er, lat, ok);
    check("be0_err", er, 32'd0);
    txn(0, 1'b0, 32'h28, 32'h0, 4'hF, rd, er, lat, ok);
    check("be0_rdata", rd, exp_be0);

    // Misaligned load.
    txn(0, 1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat, ok);
    check("mis_err", er, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_latency", lat, 32'd2);

    // Out-of-range store must not alias onto word 0.
    txn(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, rd, er, lat, ok);
    txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat, ok);
    check("oor_err", er, 32'd1);
    check("oor_rdata", rd, 32'd0);
    check("oor_latency", lat, 32'd2);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, ok);
    check("oor_word0", rd, 32'h5A5A5A5A);
    check("oor_word0_err", er, 32'd0);

    // Back-to-back loads with zero wait states.
    for (int k = 0; k < 4; k++) begin
      txn(1, 1'b1, 32'h40 + 32'(4 * k), 32'hB0B00000 + 32'(k), 4'hF, rd, er, lat, ok);
      if (k == 0) check("b2b_fill_latency", lat, 32'd0);
    end
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_be[1] = 4'hF;
    req_addr[1] = 32'h40; rsp_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b_valid%0d", k), rsp_valid[1], 32'd1);
      check($sformatf("b2b_rdata%0d", k), rsp_rdata[1], 32'hB0B00000 + 32'(k));
      check($sformatf("b2b_ready%0d", k), req_ready[1], 32'd1);
      if (k < 3) begin
        req_addr[1] = 32'h40 + 32'(4 * (k + 1));
      end else begin
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
      end
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", s), rsp_valid[1], 32'd1);
      check($sformatf("stall_rdata%0d", s), rsp_rdata[1], 32'hB0B00003);
      check($sformatf("stall_ready%0d", s), req_ready[1], 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    check("retire_valid", rsp_valid[1], 32'd0);
    check("retire_rdata", rsp_rdata[1], 32'd0);
    check("retire_busy", busy[1], 32'd0);

    // Abort a store while it is waiting.
    txn(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, er, lat, ok);
    check("ab_pre_latency", lat, 32'd3);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h30;
    req_wdata[2] = 32'h12345678; req_be[2] = 4'hF; rsp_ready[2] = 1'b1;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    check("ab_busy_wait", busy[2], 32'd1);
    reset_n = 1'b0;
    #1;
    check("ab_req_ready", req_ready[2], 32'd1);
    check("ab_rsp_valid", rsp_valid[2], 32'd0);
    check("ab_busy", busy[2], 32'd0);
    check("ab_rsp_err", rsp_err[2], 32'd0);
    check("ab_rsp_rdata", rsp_rdata[2], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("ab_no_late_rsp", rsp_valid[2], 32'd0);
    txn(2, 1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat, ok);
    check("ab_old_value", rd, 32'hCAFEF00D);
    check("ab_load_err", er, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
